// File: rtl/seq_pkg.sv
// Shared types and helpers for the sequence player: FSM states, colour sizing
// and the colour-index to one-hot LED mapping.
package seq_pkg;
  localparam int COLOR_W    = 2;
  localparam int NUM_COLORS = 4;

  typedef enum logic [2:0] {
    IDLE,
    RERUN,
    BIT0,
    BIT1,
    SHOW,
    GAP,
    DONE
  } state_t;

  function automatic logic [NUM_COLORS-1:0] color_to_led(input logic [COLOR_W-1:0] color);
    logic [NUM_COLORS-1:0] led;
    led        = '0;
    led[color] = 1'b1;
    return led;
  endfunction
endpackage

// File: rtl/seq_player_if.sv
// Connection between the game logic / LFSR side (master) and the sequence
// player (slave): round request, random bit in, LFSR controls and LEDs out.
interface seq_player_if #(
  parameter int LEN_W = 5
);
  import seq_pkg::*;

  logic                  start;
  logic [LEN_W-1:0]      len;
  logic                  random;
  logic                  step;
  logic                  rerun;
  logic [NUM_COLORS-1:0] led;
  logic [COLOR_W-1:0]    color;
  logic                  busy;
  logic                  done;

  modport master (
    output start, len, random,
    input  step, rerun, led, color, busy, done
  );

  modport slave (
    input  start, len, random,
    output step, rerun, led, color, busy, done
  );
endinterface

// File: rtl/seq_timer.sv
// Loadable down-counter shared by the SHOW and GAP phases; zero is high once
// the loaded count has run out.
module seq_timer #(
  parameter int TMR_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);
  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TMR_W'(1);
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/seq_player.sv
// Replays the LFSR colour sequence from its seed each round, one LED per element.
// Optional SEQ_PLAYER_SPEEDUP_EN halves on/off times for rounds of 8+ elements.
module seq_player
  import seq_pkg::*;
#(
  parameter int LEN_W      = 5,
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int TMR_W      = 26
) (
  input  logic         clk,
  input  logic         reset,
  seq_player_if.slave  bus
);
  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic             b0;
  logic             tmr_load;
  logic             tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  logic [TMR_W-1:0] on_load;
  logic [TMR_W-1:0] off_load;

`ifdef SEQ_PLAYER_SPEEDUP_EN
  localparam logic [TMR_W-1:0] ON_LOAD_FAST  = TMR_W'(((ON_CYCLES / 2 < 1) ? 1 : ON_CYCLES / 2) - 1);
  localparam logic [TMR_W-1:0] OFF_LOAD_FAST = TMR_W'(((OFF_CYCLES / 2 < 1) ? 1 : OFF_CYCLES / 2) - 1);
  logic fast;
  assign fast     = (32'(len_q) >= 32'd8);
  assign on_load  = fast ? ON_LOAD_FAST : ON_LOAD;
  assign off_load = fast ? OFF_LOAD_FAST : OFF_LOAD;
`else
  assign on_load  = ON_LOAD;
  assign off_load = OFF_LOAD;
`endif

  // Timer is armed for the lit phase while the second bit is fetched, and for
  // the dark phase on the last lit cycle, so neither phase loses a cycle.
  assign tmr_load = (state == BIT1) || ((state == SHOW) && tmr_zero);
  assign tmr_val  = (state == BIT1) ? on_load : off_load;

  seq_timer #(.TMR_W(TMR_W)) timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      len_q     <= '0;
      count     <= '0;
      b0        <= 1'b0;
      bus.step  <= 1'b0;
      bus.rerun <= 1'b0;
      bus.led   <= '0;
      bus.color <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.step  <= 1'b0;
      bus.rerun <= 1'b0;
      bus.done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.len != '0) begin
              len_q     <= bus.len;
              count     <= '0;
              bus.rerun <= 1'b1;
              bus.busy  <= 1'b1;
              state     <= RERUN;
            end else begin
              bus.done <= 1'b1;
              state    <= DONE;
            end
          end
        end
        RERUN: begin
          bus.step <= 1'b1;
          state    <= BIT0;
        end
        BIT0: begin
          b0       <= bus.random;
          bus.step <= 1'b1;
          state    <= BIT1;
        end
        BIT1: begin
          bus.color <= {bus.random, b0};
          bus.led   <= color_to_led({bus.random, b0});
          state     <= SHOW;
        end
        SHOW: begin
          if (tmr_zero) begin
            bus.led <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (tmr_zero) begin
            count <= count + LEN_W'(1);
            if (count + LEN_W'(1) == len_q) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              bus.step <= 1'b1;
              state    <= BIT0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_player.sv
// Bench for seq_player: stand-in LFSR, per-cycle timeline model, directed and random rounds.
`timescale 1ns/1ps
module tb_seq_player;
  import seq_pkg::*;

  localparam int LEN_W = 5;
  localparam int ON    = 4;
  localparam int OFF   = 2;
  localparam int TMR_W = 4;

  logic clk = 1'b0;
  logic reset;

  seq_player_if #(.LEN_W(LEN_W)) bus ();

  seq_player #(
    .LEN_W      (LEN_W),
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .TMR_W      (TMR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11), random = lfsr[0]
  logic [15:0] seed = 16'hACE1;
  logic [15:0] lfsr = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  always @(posedge clk) begin
    if (bus.rerun)     lfsr <= seed;
    else if (bus.step) lfsr <= lfsr_next(lfsr);
  end
  assign bus.random = lfsr[0];

  typedef struct packed {
    logic       step;
    logic       rerun;
    logic [3:0] led;
    logic [1:0] color;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   cur_idle    = 1'b1;

  // Observations of the current directed round
  logic [3:0] obs_led[$];
  logic [3:0] prev_led;
  int obs_step, obs_rerun, lit_cycles, done_at, rel;

  function automatic exp_t mk(logic st, logic rr, logic [3:0] ld, logic [1:0] c, logic bz, logic dn);
    exp_t e;
    e.step = st; e.rerun = rr; e.led = ld; e.color = c; e.busy = bz; e.done = dn;
    return e;
  endfunction

  // Expected output timeline for a round accepted at the next edge
  task automatic plan(input int n);
    int on_d, off_d;
    logic [15:0] s;
    logic [1:0] c;
    on_d  = ON;
    off_d = OFF;
`ifdef SEQ_PLAYER_SPEEDUP_EN
    if (n >= 8) begin
      on_d  = (ON / 2 < 1) ? 1 : ON / 2;
      off_d = (OFF / 2 < 1) ? 1 : OFF / 2;
    end
`endif
    if (n == 0) begin
      q.push_back(mk(0, 0, 4'b0, 2'd0, 0, 1));
      return;
    end
    q.push_back(mk(0, 1, 4'b0, 2'd0, 1, 0));
    s = seed;
    for (int k = 0; k < n; k++) begin
      c[0] = s[0]; s = lfsr_next(s);
      c[1] = s[0]; s = lfsr_next(s);
      q.push_back(mk(1, 0, 4'b0, 2'd0, 1, 0));
      q.push_back(mk(1, 0, 4'b0, 2'd0, 1, 0));
      for (int j = 0; j < on_d; j++)  q.push_back(mk(0, 0, 4'(1 << c), c, 1, 0));
      for (int j = 0; j < off_d; j++) q.push_back(mk(0, 0, 4'b0, 2'd0, 1, 0));
    end
    q.push_back(mk(0, 0, 4'b0, 2'd0, 0, 1));
  endtask

  task automatic check_cycle();
    exp_t e, a;
    cur_idle = (q.size() == 0);
    e = cur_idle ? exp_t'(0) : q.pop_front();
    a = mk(bus.step, bus.rerun, bus.led, bus.color, bus.busy, bus.done);
    if (e.led == 4'b0) a.color = e.color;
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL cycle t=%0t: got step=%b rerun=%b led=%b color=%0d busy=%b done=%b, want step=%b rerun=%b led=%b color=%0d busy=%b done=%b",
               $time, a.step, a.rerun, a.led, a.color, a.busy, a.done,
               e.step, e.rerun, e.led, e.color, e.busy, e.done);
    end
  endtask

  task automatic record();
    if (bus.step)  obs_step++;
    if (bus.rerun) obs_rerun++;
    if (bus.led != 4'b0) lit_cycles++;
    if (bus.led != 4'b0 && prev_led == 4'b0) obs_led.push_back(bus.led);
    if (bus.done && done_at < 0) done_at = rel;
    prev_led = bus.led;
    rel++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    record();
  endtask

  task automatic expect_int(input string name, input int act, input int want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!cur_idle && k < 2000) begin
      tick();
      k++;
    end
    if (!cur_idle) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: got busy after %0d cycles, want idle", k);
    end
  endtask

  task automatic start_round(input int n);
    obs_led.delete();
    obs_step = 0; obs_rerun = 0; lit_cycles = 0; done_at = -1; rel = 0;
    prev_led = 4'b0;
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    plan(n);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_round(input int n);
    wait_idle();
    start_round(n);
    wait_idle();
  endtask

  logic [3:0] first_run[$];
  int n;
  int r;

  initial begin
    bus.start = 1'b0;
    bus.len   = '0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    expect_int("reset_led", int'(bus.led), 0);
    expect_int("reset_busy", int'(bus.busy), 0);

    // len=1 from seed ACE1: colour 1, lit 4, done 9 cycles after the RERUN cycle
    run_round(1);
    expect_int("len1_rerun", obs_rerun, 1);
    expect_int("len1_step", obs_step, 2);
    expect_int("len1_nled", obs_led.size(), 1);
    if (obs_led.size() > 0) expect_int("len1_led", int'(obs_led[0]), 4'b0010);
    expect_int("len1_lit", lit_cycles, 4);
    expect_int("len1_done_at", done_at, 9);

    // len=2 twice back to back: colours 1 then 0, identical both rounds
    run_round(2);
    expect_int("len2_rerun", obs_rerun, 1);
    expect_int("len2_step", obs_step, 4);
    expect_int("len2_nled", obs_led.size(), 2);
    if (obs_led.size() == 2) begin
      expect_int("len2_led0", int'(obs_led[0]), 4'b0010);
      expect_int("len2_led1", int'(obs_led[1]), 4'b0001);
    end
    expect_int("len2_done_at", done_at, 17);
    first_run = obs_led;
    run_round(2);
    expect_int("replay_n", obs_led.size(), first_run.size());
    for (int i = 0; i < obs_led.size() && i < first_run.size(); i++)
      expect_int("replay_led", int'(obs_led[i]), int'(first_run[i]));

    // len=0: done in the first cycle, nothing else
    run_round(0);
    expect_int("len0_done_at", done_at, 0);
    expect_int("len0_step", obs_step, 0);
    expect_int("len0_rerun", obs_rerun, 0);
    expect_int("len0_nled", obs_led.size(), 0);

    // reset during SHOW of the first element of a len=3 round
    wait_idle();
    start_round(3);
    for (int k = 0; k < 20 && obs_led.size() == 0; k++) tick();
    tick();
    reset = 1'b1;
    q.delete();
    tick();
    reset = 1'b0;
    expect_int("abort_led", int'(bus.led), 0);
    expect_int("abort_busy", int'(bus.busy), 0);
    run_round(3);
    expect_int("abort_replay_nled", obs_led.size(), 3);
    if (obs_led.size() > 0) expect_int("abort_replay_led0", int'(obs_led[0]), 4'b0010);

    // len=8: colours 1,0,2,3,0,3,2,2 from seed ACE1
    run_round(8);
    expect_int("len8_step", obs_step, 16);
    expect_int("len8_nled", obs_led.size(), 8);
    if (obs_led.size() == 8) begin
      expect_int("len8_led2", int'(obs_led[2]), 4'b0100);
      expect_int("len8_led3", int'(obs_led[3]), 4'b1000);
    end
`ifdef SEQ_PLAYER_SPEEDUP_EN
    expect_int("len8_lit", lit_cycles, 16);
    expect_int("len8_done_at", done_at, 3 + 8 * (2 + 1 + 2) - 2);
`else
    expect_int("len8_lit", lit_cycles, 32);
    expect_int("len8_done_at", done_at, 3 + 8 * (ON + OFF + 2) - 2);
`endif

    // random rounds, ignored starts, random seeds and mid-round resets
    for (int i = 0; i < 4000; i++) begin
      bus.start = 1'b0;
      reset     = 1'b0;
      if (cur_idle) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 4) == 0) seed = 16'($urandom_range(1, 65535));
          n = $urandom_range(0, 10);
          bus.start = 1'b1;
          bus.len   = LEN_W'(n);
          plan(n);
        end
      end else begin
        r = $urandom_range(0, 99);
        if (r < 2) begin
          reset = 1'b1;
          q.delete();
        end else if (r < 10) begin
          bus.start = 1'b1;
          bus.len   = LEN_W'($urandom);
        end
      end
      tick();
    end
    bus.start = 1'b0;
    reset     = 1'b0;
    wait_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
